// File: rtl/alu_pkg.sv
// Shared ALU control codes, multiply step count and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;

  localparam int unsigned MUL_STEPS = 32;

  typedef logic [1:0] alu_state_t;
  localparam alu_state_t IDLE = 2'd0;
  localparam alu_state_t MUL  = 2'd1;
  localparam alu_state_t DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Start/done request bus between the operand mux and the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUctr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, ALUctr, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, ALUctr, a, b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial product per step, low word only.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             last_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  count_q, count_d;

  // Accumulator value after the current step; the top captures it on the last step.
  assign acc_next_o = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_o     = step_i && (count_q == CntW'(WIDTH - 1));

  // Load operands on acceptance, otherwise advance one shift-add step when asked.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = acc_next_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CntW'(1);
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with start/done handshake; code 0111 runs a multi-cycle multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] simple_res;
  logic             simple_ovf;

  // A multiply in flight blocks new requests; DONE accepts like IDLE.
  assign accept = bus.start && (state_q != MUL);
  assign is_mul = (bus.ALUctr == ALU_MUL);
  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept && is_mul),
    .step_i     (state_q == MUL),
    .a_i        (bus.a),
    .b_i        (bus.b),
    .acc_next_o (mul_acc_next),
    .last_o     (mul_last)
  );

  // Single-cycle result and signed-overflow decode.
  always_comb begin
    simple_res = '0;
    simple_ovf = 1'b0;
    case (bus.ALUctr)
      ALU_ADD: begin
        simple_res = sum;
        simple_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SUB: begin
        simple_res = diff;
        simple_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_AND: simple_res = bus.a & bus.b;
      ALU_OR:  simple_res = bus.a | bus.b;
      ALU_XOR: simple_res = bus.a ^ bus.b;
      ALU_LUI: simple_res[WIDTH-1 -: 16] = bus.b[15:0];
      ALU_SLT: simple_res = {{(WIDTH - 1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: ; // undefined codes complete normally with a zero result
    endcase
  end

  // FSM next state and completion-time output capture.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (state_q == MUL) begin
      if (mul_last) begin
        state_d  = DONE;
        result_d = mul_acc_next;
        zero_d   = (mul_acc_next == '0);
        ovf_d    = 1'b0;
      end
    end else if (accept) begin
      if (is_mul) begin
        state_d = MUL;
      end else begin
        state_d  = DONE;
        result_d = simple_res;
        zero_d   = (simple_res == '0);
        ovf_d    = simple_ovf;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == MUL);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the operation definitions using wide arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic v);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint t;
    logic [63:0] p;
    r = '0;
    v = 1'b0;
    case (op)
      4'd0: begin t = sa + sb; r = t[31:0]; v = (t > SMAX) || (t < SMIN); end
      4'd1: begin t = sa - sb; r = t[31:0]; v = (t > SMAX) || (t < SMIN); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = {b[15:0], 16'h0000};
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default: r = '0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op);
    return (op == ALU_MUL) ? MUL_STEPS + 1 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from idle/done; inputs scrambled after acceptance to prove capture.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] er;
    logic        ev;
    int          lat;
    model(op, a, b, er, ev);
    bus.start = 1'b1;
    bus.ALUctr = op;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
    bus.ALUctr = 4'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    if (op == ALU_MUL) chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(latency(op)));
    chk({tag, ".res"}, bus.result, er);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(er == 32'd0));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ev));
    chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] er, last_r;
    logic        ev;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          k;

    bus.start = 1'b0;
    bus.ALUctr = 4'd0;
    bus.a = '0;
    bus.b = '0;

    // Reset values
    tick();
    tick();
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.res", bus.result, 32'd0);
    chk("rst.zero", 32'(bus.zero), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();

    run_op("add5_7", ALU_ADD, 32'd5, 32'd7);
    run_op("addovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    run_op("subovf", ALU_SUB, 32'h8000_0000, 32'd1);
    run_op("subzero", ALU_SUB, 32'd3, 32'd3);
    run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("or", ALU_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("lui", ALU_LUI, 32'hDEAD_BEEF, 32'h0000_1234);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    run_op("sltn", ALU_SLT, 32'd1, 32'hFFFF_FFFF);
    run_op("undef", 4'b1010, 32'h1234_5678, 32'h1111_1111);
    run_op("mul1", ALU_MUL, 32'h0001_0003, 32'h0000_0005);
    run_op("mulff", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Constant-value spot checks of the model-independent expectations
    chk("mulff.const", bus.result, 32'h0000_0001);

    // Held start: one add completes every cycle
    bus.start = 1'b1;
    bus.ALUctr = ALU_ADD;
    for (int i = 0; i < 8; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      model(ALU_ADD, bus.a, bus.b, er, ev);
      tick();
      chk($sformatf("stream%0d.done", i), 32'(bus.done), 32'd1);
      chk($sformatf("stream%0d.res", i), bus.result, er);
      chk($sformatf("stream%0d.ovf", i), 32'(bus.overflow), 32'(ev));
    end
    last_r = er;
    bus.start = 1'b0;
    tick();
    chk("stream.end_done", 32'(bus.done), 32'd0);
    chk("stream.hold", bus.result, last_r);

    // Start pulses during a multiply are ignored
    bus.start = 1'b1;
    bus.ALUctr = ALU_MUL;
    bus.a = 32'h0001_0003;
    bus.b = 32'h0000_0005;
    tick();
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 64) begin
      if (k == 3) begin
        bus.start = 1'b1;
        bus.ALUctr = ALU_ADD;
        bus.a = $urandom;
        bus.b = $urandom;
      end else if (k == 10) begin
        bus.start = 1'b1;
        bus.ALUctr = ALU_MUL;
        bus.a = 32'h0000_0007;
        bus.b = 32'h0000_0009;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      k++;
    end
    bus.start = 1'b0;
    chk("ign.lat", 32'(k), 32'(MUL_STEPS + 1));
    chk("ign.res", bus.result, 32'h0005_000F);
    tick();
    chk("ign.noqueue", 32'(bus.done), 32'd0);
    chk("ign.hold", bus.result, 32'h0005_000F);

    // Reset in the middle of a multiply
    bus.start = 1'b1;
    bus.ALUctr = ALU_MUL;
    bus.a = 32'h1234_5678;
    bus.b = 32'h0000_0003;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("rstmid.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.busy", 32'(bus.busy), 32'd0);
    chk("rstmid.done", 32'(bus.done), 32'd0);
    chk("rstmid.res", bus.result, 32'd0);
    chk("rstmid.zero", 32'(bus.zero), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rstmid.nodone", 32'(bus.done), 32'd0);
    run_op("sub9_4", ALU_SUB, 32'd9, 32'd4);

    // Randomized operations, with some equal operands for zero results
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 5) == 0) ra = 32'h7FFF_FFFF;
      run_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered execute-stage ALU that consumes the 4-bit `ALUctr` code from the ALU control decoder together with two 32-bit operands, and returns a registered result, zero flag and signed-overflow flag under a start/done handshake. Single-operation codes finish in one cycle. The new code `0111` (unsigned multiply, low word) runs as a 32-step iterative shift-add. The block sits between the register-file/immediate operand mux and the writeback/branch-compare logic, letting the datapath add a multi-cycle operation without changing the decoder's existing encodings.

## Interface
- `WIDTH`, 32, operand/result width; the multiply counter is sized for `WIDTH` steps.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; accepted only while `busy`=0.
- `ALUctr` input 4: operation code, sampled on acceptance.
- `a` input WIDTH: operand A (rs), sampled on acceptance.
- `b` input WIDTH: operand B (rt/immediate), sampled on acceptance.
- `busy` output 1: high while a multiply is iterating.
- `done` output 1: one-cycle pulse; `result`/`zero`/`overflow` valid in that cycle.
- `result` output WIDTH: registered result, held until the next completion.
- `zero` output 1: `result`==0, registered with `result`.
- `overflow` output 1: signed overflow for add/sub, registered with `result`.

## Operation
- Codes:
  - `0000` add: a+b.
  - `0001` sub: a−b.
  - `0010` and.
  - `0011` or.
  - `0100` xor.
  - `0101` lui: {b[15:0],16'h0}.
  - `0110` slt: signed a<b → 1 else 0.
  - `0111` mul: low WIDTH bits of unsigned a×b.
- Undefined codes (`1000`–`1111`): result 0, overflow 0, normal 1-cycle completion.
- overflow:
  - add: operands have the same sign and the sum's sign differs.
  - sub: operands have different signs and the result's sign differs from a.
  - all other ops: 0.
- FSM states:
  - IDLE: accept on start → DONE (simple op) or MUL (`0111`).
  - MUL: one shift-add step per cycle; after the 32nd step → DONE.
  - DONE: done=1 for one cycle; accepting start here is legal (back-to-back) and transitions as from IDLE; otherwise → IDLE.
- Mul datapath: on acceptance load multiplicand=a, multiplier=b, acc=0, count=0. Each MUL cycle:
  - if multiplier[0], acc += multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1; count++.
- Input capture: a, b and ALUctr are captured only on acceptance; later changes do not affect an operation in flight.
- start while busy=1 is ignored entirely: no queueing, no effect on the current operation.

## Timing
- Reset values: busy=0, done=0, result=0, zero=0, overflow=0; state IDLE; counter 0.
- Simple op: start accepted at edge N → result/zero/overflow updated at edge N, done=1 during cycle N..N+1. Latency 1.
- Mul: accepted at edge N → busy=1 from N through N+32; result written and busy=0 at edge N+32; done high in the following cycle. Latency 33.
- Throughput: one simple op per cycle when start is held high (DONE→DONE).
- Reset asserted mid-multiply: immediate abort, all outputs return to reset values, no done pulse; the first start after deassertion is accepted normally.
- result/zero/overflow never change except at a completion edge or reset.

## Structure
- Shared package `alu_pkg`:
  - `ALU_ADD`…`ALU_MUL` 4-bit code constants.
  - FSM state typedef (IDLE, MUL, DONE).
  - `MUL_STEPS`=32.
- The decoder gains the `0111` mapping from the same constants.
- One sub-module, `alu_mul_iter`, holds the multiplicand/multiplier/acc/count registers with load and step inputs and a last-step output. The FSM and single-cycle logic stay in `alu_seq`.

## Test plan
- Reset: assert rst, check all outputs 0; release, start add a=5 b=7 → next cycle done=1, result=12, zero=0, overflow=0.
- Signed overflow: add 0x7FFFFFFF+1 → result 0x80000000, overflow=1; sub 0x80000000−1 → 0x7FFFFFFF, overflow=1; sub 3−3 → result 0, zero=1.
- Logic/lui/slt: and/or/xor on 0xF0F0_F0F0 and 0x0FF0_0FF0 → 0x00F0_00F0 / 0xFFF0_FFF0 / 0xFF00_FF00; lui b=0x1234 → 0x12340000; slt a=−1 b=1 → 1; code `1010` → result 0, done after 1 cycle.
- Multiply: a=0x0001_0003, b=0x0000_0005 → busy for 32 cycles, done on cycle 33 after start, result 0x0005_000F; a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000001.
- Handshake: start held high with a changing add stream → done every cycle with the correct sums; start pulses during MUL are ignored and the mul result is unchanged.
- Reset mid-mul: assert rst at cycle 10 of a multiply → outputs 0, no done; a following sub 9−4 → 5 after 1 cycle.
